// File: rtl/encoder42_enable_high_seq.sv
// 4-to-2 request encoder with a pending register, valid/ready drain and an overflow pulse.
// Define ROUND_ROBIN_EN for rotating grant order; the default build uses fixed priority 3>2>1>0.
module encoder42_enable_high_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       e,
  input  logic [3:0] w,
  input  logic       rdy,
  output logic [1:0] y,
  output logic       v,
  output logic       err
);

  localparam int unsigned N  = 4;
  localparam int unsigned YW = 2;

  logic [N-1:0]  p_q, p_d;
  logic [N-1:0]  clr, cap;
  logic [YW-1:0] y_q, y_d;
  logic          v_q, v_d;
  logic          err_q, err_d;

`ifdef ROUND_ROBIN_EN
  logic [YW-1:0] ptr_q, ptr_d;

  // First set bit searching upward from last+1, wrapping modulo 4.
  function automatic logic [YW-1:0] grant(input logic [N-1:0] req, input logic [YW-1:0] last);
    logic [YW-1:0] idx;
    logic          found;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = last + YW'(k);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  endfunction
`else
  function automatic logic [YW-1:0] grant(input logic [N-1:0] req);
    if (req[3])      grant = 2'd3;
    else if (req[2]) grant = 2'd2;
    else if (req[1]) grant = 2'd1;
    else             grant = 2'd0;
  endfunction
`endif

  // Outputs are precomputed from next pending state so y/v never see w or e combinationally.
  always_comb begin
    cap   = e ? w : '0;
    clr   = (v_q && rdy) ? (N'(1) << y_q) : '0;
    p_d   = (p_q & ~clr) | cap;
    err_d = |(cap & p_q & ~clr);
    v_d   = |p_d;
`ifdef ROUND_ROBIN_EN
    ptr_d = (v_q && rdy) ? y_q : ptr_q;
    y_d   = grant(p_d, ptr_d);
`else
    y_d   = grant(p_d);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      y_q   <= '0;
      v_q   <= 1'b0;
      err_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ptr_q <= 2'b11;
`endif
    end else begin
      p_q   <= p_d;
      y_q   <= y_d;
      v_q   <= v_d;
      err_q <= err_d;
`ifdef ROUND_ROBIN_EN
      ptr_q <= ptr_d;
`endif
    end
  end

  assign y   = y_q;
  assign v   = v_q;
  assign err = err_q;

endmodule

// File: tb/tb_encoder42_enable_high_seq.sv
// Bench for encoder42_enable_high_seq: directed table, corner sequences, random vs reference model.
module tb_encoder42_enable_high_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       e;
  logic [3:0] w;
  logic       rdy;
  logic [1:0] y;
  logic       v;
  logic       err;

  int total = 0;
  int bad   = 0;

  // Reference state: pending set and last transferred index.
  bit m_p [4];
  int m_ptr;
  int m_y, m_v, m_err;

  encoder42_enable_high_seq dut (
    .clk(clk), .rst_n(rst_n), .e(e), .w(w), .rdy(rdy),
    .y(y), .v(v), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       e;
    bit [3:0] w;
    bit       rdy;
    int       ey;
    int       ev;
    int       eerr;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    int any;
    any = 0;
    for (int i = 0; i < 4; i++) any += int'(m_p[i]);
    if (any == 0) return 0;
`ifdef ROUND_ROBIN_EN
    for (int off = 1; off <= 4; off++)
      if (m_p[(m_ptr + off) % 4]) return (m_ptr + off) % 4;
`else
    for (int i = 3; i >= 0; i--)
      if (m_p[i]) return i;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_p[i] = 1'b0;
    m_ptr = 3; m_y = 0; m_v = 0; m_err = 0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input bit ie, input bit [3:0] iw, input bit irdy);
    int  gy;
    bit  xfer, dup, cleared, req;
    gy   = model_grant();
    xfer = (m_v != 0) && irdy;
    dup  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cleared = xfer && (i == gy);
      req     = ie && iw[i];
      if (req && m_p[i] && !cleared) dup = 1'b1;
      m_p[i] = (m_p[i] && !cleared) || req;
    end
    if (xfer) m_ptr = gy;
    m_err = int'(dup);
    m_v   = 0;
    for (int i = 0; i < 4; i++) if (m_p[i]) m_v = 1;
    m_y = model_grant();
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input bit ie, input bit [3:0] iw, input bit irdy);
    e = ie; w = iw; rdy = irdy;
    @(posedge clk);
    model_edge(ie, iw, irdy);
    #1;
  endtask

  task automatic do_reset();
    e = 1'b0; w = 4'b0000; rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; e = 1'b0; w = 4'b0000; rdy = 1'b0;
    model_reset();
    #3;
    chk("reset_y",   int'(y),   0);
    chk("reset_v",   int'(v),   0);
    chk("reset_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: two-code drain, ignored requests, duplicate, clear+re-request.
`ifdef ROUND_ROBIN_EN
    tbl[0] = '{1'b1, 4'b1010, 1'b1, 1, 1, 0};
    tbl[1] = '{1'b0, 4'b0000, 1'b1, 3, 1, 0};
`else
    tbl[0] = '{1'b1, 4'b1010, 1'b1, 3, 1, 0};
    tbl[1] = '{1'b0, 4'b0000, 1'b1, 1, 1, 0};
`endif
    tbl[2]  = '{1'b0, 4'b0000, 1'b1, 0, 0, 0};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 0, 0, 0};
    tbl[4]  = '{1'b0, 4'b1111, 1'b0, 0, 0, 0};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 0, 0, 0};
    tbl[6]  = '{1'b0, 4'b1111, 1'b0, 0, 0, 0};
    tbl[7]  = '{1'b1, 4'b0001, 1'b0, 0, 1, 0};
    tbl[8]  = '{1'b1, 4'b0001, 1'b0, 0, 1, 1};
    tbl[9]  = '{1'b0, 4'b0000, 1'b0, 0, 1, 0};
    tbl[10] = '{1'b0, 4'b0000, 1'b1, 0, 0, 0};
    tbl[11] = '{1'b1, 4'b0100, 1'b0, 2, 1, 0};
    tbl[12] = '{1'b1, 4'b0100, 1'b1, 2, 1, 0};
    tbl[13] = '{1'b0, 4'b0000, 1'b1, 0, 0, 0};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].e, tbl[i].w, tbl[i].rdy);
      chk($sformatf("tbl%0d_y", i),   int'(y),   tbl[i].ey);
      chk($sformatf("tbl%0d_v", i),   int'(v),   tbl[i].ev);
      chk($sformatf("tbl%0d_err", i), int'(err), tbl[i].eerr);
    end

    // Full recapture every cycle with rdy held high.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b1111, 1'b1);
`ifdef ROUND_ROBIN_EN
      chk($sformatf("rr_seq%0d_y", i), int'(y), i % 4);
`else
      chk($sformatf("fix_seq%0d_y", i), int'(y), 3);
`endif
      chk($sformatf("seq%0d_v", i), int'(v), 1);
    end

    // Asynchronous reset between edges with p=1011 and err high.
    do_reset();
    step(1'b1, 4'b1011, 1'b0);
    step(1'b1, 4'b1011, 1'b0);
    chk("pre_rst_err", int'(err), 1);
    chk("pre_rst_v",   int'(v),   1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y",   int'(y),   0);
    chk("async_rst_v",   int'(v),   0);
    chk("async_rst_err", int'(err), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 4'b1111, 1'b1);
      chk($sformatf("post_rst%0d_v", i), int'(v), 0);
      chk($sformatf("post_rst%0d_y", i), int'(y), 0);
    end

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bit       re, rr;
      bit [3:0] rw;
      if (n == 200) do_reset();
      re = 1'($urandom_range(0, 1));
      rw = 4'($urandom_range(0, 15));
      rr = ($urandom % 4) != 0;
      step(re, rw, rr);
      chk($sformatf("rnd%0d_y", n),   int'(y),   m_y);
      chk($sformatf("rnd%0d_v", n),   int'(v),   m_v);
      chk($sformatf("rnd%0d_err", n), int'(err), m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder42_enable_high_seq.md
ENCODER42_ENABLE_HIGH_SEQ -- requirements
Module: encoder42_enable_high_seq

Interface
REQ-001 Parameters SHALL be none; width is fixed at 4 request lines and a 2-bit code.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 e  input  1  capture enable, active-high; w is ignored when e=0.
REQ-005 w  input  4  request lines, any number set per cycle; bit i requests code i.
REQ-006 rdy  input  1  consumer ready; a transfer occurs in a cycle where v=1 and rdy=1.
REQ-007 y  output  2  encoded index of the currently granted pending request.
REQ-008 v  output  1  valid; high when at least one request is pending.
REQ-009 err  output  1  overflow pulse, one cycle wide.

Function
REQ-010 Block SHALL hold a 4-bit pending register p, updated each edge as (p & ~clr) | (e ? w : 4'b0000).
REQ-011 clr SHALL be one-hot at bit y when v=1 and rdy=1, and 4'b0000 otherwise.
REQ-012 v SHALL equal |p, decoded from registered state with no combinational path from w or e.
REQ-013 y SHALL be the grant index per REQ-015/REQ-024 and SHALL be 2'b00 when v=0.
REQ-014 Capture-to-valid latency SHALL be one cycle: w sampled at edge N gives v=1 after edge N.
REQ-015 Fixed priority SHALL be 3 > 2 > 1 > 0.
REQ-016 y and v SHALL stay stable while v=1 and rdy=0; p only gains bits, and a higher-priority new bit may change y.
REQ-017 A transfer SHALL clear exactly one bit per cycle; throughput SHALL be one code per cycle.
REQ-018 If a bit is cleared and re-requested in the same cycle, the bit SHALL remain set and err SHALL stay 0.
REQ-019 err SHALL pulse high for the cycle after an edge where e=1 and w[i]=1 for some i with p[i]=1 not being cleared; the duplicate is merged.
REQ-020 With e=1 and w=4'b0000, p SHALL behave as with e=0.
REQ-021 rdy with v=0 SHALL have no effect.

Reset
REQ-022 rst_n=0 SHALL immediately clear p to 4'b0000, y to 2'b00, v to 0, err to 0 and the round-robin pointer to 2'b11, regardless of clk.
REQ-023 Reset asserted mid-operation SHALL discard all pending requests; after release, the first capture SHALL need e=1 on a rising edge.

Configuration
REQ-024 Macro ROUND_ROBIN_EN SHALL select the grant order.
- Defined: a 2-bit pointer holds the last transferred index and is updated on each transfer.
- Defined: the grant is the first set bit of p searching ascending from pointer+1, mod 4.
- Undefined: fixed priority per REQ-015; no pointer register exists.
REQ-025 All other behaviour SHALL be identical with and without ROUND_ROBIN_EN.

Verification
REQ-026 Reset, then e=1, w=4'b1010, rdy=1 for one cycle, then e=0 -> fixed: y=3, then y=1, then v=0; ROUND_ROBIN_EN: y=1, then y=3.
REQ-027 e=0, w=4'b1111 for 4 cycles -> v=0 throughout, err=0.
REQ-028 rdy=0, e=1, w=4'b0001, then e=1, w=4'b0001 again -> err=1 for one cycle, p=4'b0001, y=0, v=1 held.
REQ-029 p=4'b0100, rdy=1, e=1, w=4'b0100 same cycle -> p stays 4'b0100, err=0, v=1.
REQ-030 ROUND_ROBIN_EN, w=4'b1111 recaptured every cycle, rdy=1 -> y sequence 0,1,2,3,0; fixed build -> y=3 every cycle.
REQ-031 p=4'b1011, rst_n pulsed low between edges -> y=0, v=0, err=0 immediately; no output for 2 cycles after release with e=0.
